// File: rtl/memory_pkg.sv
// Shared MEM-stage types: bus bundles, pipeline registers, access sizes.
// The misalign helper is used only when MISALIGN_CHECK_EN is defined.
package memory_pkg;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    MSIZE1,
    MSIZE2,
    MSIZE4,
    MSIZE8
  } msize_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mem_state_t;

  typedef struct packed {
    logic   RegWrite;
    logic   MemRead;
    logic   MemWrite;
    logic   MemUnsigned;
    msize_t MemSize;
  } control_t;

  typedef struct packed {
    word_t    pc;
    control_t ctl;
    word_t    alu;
    word_t    rs2;
    logic     valid;
  } execute_data_t;

  typedef struct packed {
    logic       valid;
    word_t      addr;
    msize_t     size;
    logic [7:0] strobe;
    word_t      data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    word_t    pc;
    control_t ctl;
    word_t    alu;
    word_t    result;
    logic     valid;
    logic     misalign;
  } memory_data_t;

  function automatic logic misaligned(
    input msize_t     size,
    input logic [2:0] off
  );
    logic m;
    m = 1'b0;
    unique case (size)
      MSIZE2:  m = off[0];
      MSIZE4:  m = |off[1:0];
      MSIZE8:  m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/memory_align.sv
// Byte-lane steering: store strobe/data placement and load
// extraction with sign or zero extension.
module mem_align
  import memory_pkg::*;
(
  input  logic [2:0] off,
  input  msize_t     size,
  input  logic       isUnsigned,
  input  word_t      storeIn,
  input  word_t      loadIn,
  output logic [7:0] strobe,
  output word_t      storeData,
  output word_t      loadData
);

  logic [5:0] sh;
  word_t      raw;
  logic       sx;

  assign sh = {off, 3'b000};
  assign raw = loadIn >> sh;

  always_comb begin
    strobe    = 8'h00;
    storeData = storeIn << sh;
    loadData  = raw;
    sx        = 1'b0;
    unique case (size)
      MSIZE1: begin
        strobe   = 8'h01 << off;
        sx       = ~isUnsigned & raw[7];
        loadData = {{56{sx}}, raw[7:0]};
      end
      MSIZE2: begin
        strobe   = 8'h03 << off;
        sx       = ~isUnsigned & raw[15];
        loadData = {{48{sx}}, raw[15:0]};
      end
      MSIZE4: begin
        strobe   = 8'h0F << off;
        sx       = ~isUnsigned & raw[31];
        loadData = {{32{sx}}, raw[31:0]};
      end
      MSIZE8: begin
        strobe    = 8'hFF;
        storeData = storeIn;
        loadData  = raw;
      end
      default: begin
        strobe = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/memory.sv
// MEM stage: one dbus access per instruction, stall until data_ok.
// Define MISALIGN_CHECK_EN to trap misaligned accesses locally.
module memory
  import memory_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          advance,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          mem_wait
);

  mem_state_t state, nextState;
  word_t      held;
  logic       isMem, bad, acc;
  logic       latchEn, reqValid, stall, useHeld;
  logic [7:0] strobe;
  word_t      stData, ldData;
  logic       unusedAddrOk;

  assign unusedAddrOk = dresp.addr_ok;
  assign isMem = dataE.ctl.MemRead | dataE.ctl.MemWrite;

`ifdef MISALIGN_CHECK_EN
  assign bad = isMem &
    misaligned(dataE.ctl.MemSize, dataE.alu[2:0]);
`else
  assign bad = 1'b0;
`endif

  assign acc = dataE.valid & isMem & ~bad;

  mem_align uAlign (
    .off       (dataE.alu[2:0]),
    .size      (dataE.ctl.MemSize),
    .isUnsigned(dataE.ctl.MemUnsigned),
    .storeIn   (dataE.rs2),
    .loadIn    (dresp.data),
    .strobe    (strobe),
    .storeData (stData),
    .loadData  (ldData)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      held  <= '0;
    end else begin
      state <= nextState;
      if (latchEn) held <= ldData;
    end
  end

  always_comb begin
    nextState = state;
    latchEn   = 1'b0;
    reqValid  = 1'b0;
    stall     = 1'b0;
    useHeld   = 1'b0;
    unique case (state)
      IDLE: begin
        reqValid = acc;
        if (acc) begin
          if (!dresp.data_ok) begin
            nextState = REQ;
            stall     = 1'b1;
          end else if (!advance) begin
            nextState = DONE;
            latchEn   = 1'b1;
          end
        end
      end
      REQ: begin
        reqValid = 1'b1;
        if (!dresp.data_ok) begin
          stall = 1'b1;
        end else if (advance) begin
          nextState = IDLE;
        end else begin
          nextState = DONE;
          latchEn   = 1'b1;
        end
      end
      DONE: begin
        useHeld = 1'b1;
        if (advance) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    dreq.valid  = reqValid;
    dreq.addr   = dataE.alu;
    dreq.size   = dataE.ctl.MemSize;
    dreq.strobe = dataE.ctl.MemWrite ? strobe : 8'h00;
    dreq.data   = stData;

    dataM.pc       = dataE.pc;
    dataM.ctl      = dataE.ctl;
    dataM.alu      = dataE.alu;
    dataM.result   = dataE.alu;
    dataM.valid    = dataE.valid & ~stall;
    dataM.misalign = bad;
    if (dataE.ctl.MemRead & ~bad)
      dataM.result = useHeld ? held : ldData;

    mem_wait = stall;

    // Bus and pipeline see silence the instant reset rises.
    if (reset) begin
      dreq     = '0;
      dataM    = '0;
      mem_wait = 1'b0;
    end
  end

endmodule
